// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the NES bus masters (OAM DMA, later DMC DMA).
//   dma_state_t  : sprite-DMA sequencer states
//   bus_req_t    : one system-bus request {addr, data, ren, wen}
//   ADDR_OAMDMA  : CPU register that launches sprite DMA ($4014)
//   ADDR_OAMDATA : PPU OAM data port written by every DMA store ($2004)
package nes_bus_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        ren;
        logic        wen;
    } bus_req_t;

    // True in every state where the DMA, not the CPU, drives the bus.
    function automatic logic dma_owns_bus(input dma_state_t st);
        return (st == ALIGN) || (st == READ) || (st == WRITE);
    endfunction

endpackage

// File: rtl/nes_bus_mux.sv
// CPU / DMA system-bus selector. Purely combinational so the CPU sees a
// zero-latency passthrough whenever no DMA engine owns the bus.
// Ports:
//   sel_dma  in  1 = drive dma_req onto the bus, 0 = drive cpu_req
//   cpu_req  in  request from the CPU core
//   dma_req  in  request from a DMA engine
//   bus_req  out request presented to the system address decoder
module nes_bus_mux
    import nes_bus_pkg::*;
(
    input  logic     sel_dma,
    input  bus_req_t cpu_req,
    input  bus_req_t dma_req,
    output bus_req_t bus_req
);

    assign bus_req = sel_dma ? dma_req : cpu_req;

endmodule

// File: rtl/nes_oam_dma.sv
// Sprite (OAM) DMA bus master placed between cpu_top and the address decoder.
// A CPU write to DMA_REG_ADDR latches a source page, stalls the CPU through
// cpu_rdy, then copies $XX00-$XXFF to OAM_DATA_ADDR as alternating read/write
// cycles. When idle the CPU bus passes straight through.
//
// Build option: define OAM_DMA_ALIGN_EN to model the 2A03 GET/PUT cycle
// parity; a halt cycle landing on GET then costs one extra ALIGN cycle
// (514 instead of 513 cycles). Without it, reads follow the halt cycle
// directly and a transfer always takes 513 cycles.
//
// Ports:
//   clk, rst        CPU clock, synchronous active-high reset
//   cpu_addr        CPU address            cpu_data_out  CPU write data
//   cpu_ren         CPU read strobe        cpu_wen       CPU write strobe
//   cpu_rdy         0 stalls CPU read cycles
//   bus_addr        system bus address     bus_data_out  system bus write data
//   bus_ren         system bus read strobe bus_wen       system bus write strobe
//   bus_data_in     system bus read data, valid in the same cycle as bus_ren
//   dma_active      high while the DMA owns the bus
module nes_oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [7:0]  bus_data_in,
    output logic        dma_active
);

    dma_state_t  state;
    dma_state_t  state_nxt;
    dma_state_t  halt_dst;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_q;
    logic        dma_trig;
    bus_req_t    cpu_req;
    bus_req_t    dma_req;
    bus_req_t    bus_req;

    assign dma_trig = cpu_wen && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    // parity=0 is a GET cycle, parity=1 a PUT cycle.
    logic parity;

    always_ff @(posedge clk) begin
        if (rst) parity <= 1'b0;
        else     parity <= ~parity;
    end

    // Halt cycle on PUT means the next cycle is GET and reads can start
    // immediately; otherwise burn one ALIGN cycle so every READ is a GET.
    assign halt_dst = parity ? READ : ALIGN;
`else
    assign halt_dst = READ;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dma_trig) state_nxt = HALT;
            // The 6502 ignores rdy on writes, so the halt only takes hold
            // on the first non-write cycle.
            HALT:    if (!cpu_wen) state_nxt = halt_dst;
            ALIGN:   state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (idx == 8'hFF) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            data_q <= 8'h00;
        end else begin
            state <= state_nxt;
            // Only an IDLE-state trigger may load the page; later $4014
            // writes are ignored until the transfer finishes.
            if (state == IDLE && dma_trig) page <= cpu_data_out;
            if (state == READ)             data_q <= bus_data_in;
            // 8-bit increment: wraps to 0 after the last byte, never
            // carries into the page.
            if (state == WRITE)            idx <= idx + 8'd1;
        end
    end

    assign cpu_req = '{addr: cpu_addr, data: cpu_data_out,
                       ren: cpu_ren, wen: cpu_wen};

    always_comb begin
        dma_req.addr = {page, idx};
        dma_req.data = data_q;
        dma_req.ren  = 1'b0;
        dma_req.wen  = 1'b0;
        case (state)
            READ:    dma_req.ren = 1'b1;
            WRITE: begin
                dma_req.addr = OAM_DATA_ADDR;
                dma_req.wen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign dma_active = dma_owns_bus(state);
    assign cpu_rdy    = (state == IDLE);

    nes_bus_mux u_mux (
        .sel_dma (dma_active),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .bus_req (bus_req)
    );

    assign bus_addr     = bus_req.addr;
    assign bus_data_out = bus_req.data;
    assign bus_ren      = bus_req.ren;
    assign bus_wen      = bus_req.wen;

endmodule

// File: tb/tb_nes_oam_dma.sv
`timescale 1ns/1ps
module tb_nes_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_ren;
    logic        bus_wen;
    logic [7:0]  bus_data_in;
    logic        dma_active;

    always #5 clk = ~clk;

    nes_oam_dma dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_ren      (cpu_ren),
        .cpu_wen      (cpu_wen),
        .cpu_rdy      (cpu_rdy),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_ren      (bus_ren),
        .bus_wen      (bus_wen),
        .bus_data_in  (bus_data_in),
        .dma_active   (dma_active)
    );

    // System memory behind the bus (read side only matters for DMA).
    logic [7:0] mem [65536];
    assign bus_data_in = mem[bus_addr];

    int tests = 0;
    int fails = 0;
    int shown = 0;

    // Reference model state: cycle number since reset, mode
    // (0 idle, 1 halted waiting for a non-write, 2 transferring),
    // page, and the cycle on which the first DMA read happens.
    int         cyc = 0;
    int         mode = 0;
    logic [7:0] m_page = 8'h00;
    int         rs = 0;

    logic [7:0]  wq[$];
    logic [15:0] rq[$];

    // Per-cycle comparison against the model, plus a log of DMA accesses.
    initial begin
        logic        e_rdy, e_act, e_ren, e_wen, chk_a, chk_d, bad;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic [7:0]  b8;
        int          k;
        forever begin
            @(negedge clk);
            if (rst) begin
                mode = 0; cyc = 0; m_page = 8'h00;
            end else begin
                e_rdy = (mode == 0); e_act = 1'b0;
                e_addr = cpu_addr; e_data = cpu_data_out;
                e_ren = cpu_ren; e_wen = cpu_wen; chk_a = 1'b1; chk_d = 1'b1;
                if (mode == 2) begin
                    e_act = 1'b1; e_ren = 1'b0; e_wen = 1'b0; chk_a = 1'b0; chk_d = 1'b0;
                    if (cyc >= rs) begin
                        k  = cyc - rs;
                        b8 = 8'(k / 2);
                        chk_a = 1'b1;
                        if (k % 2 == 0) begin
                            e_ren = 1'b1; e_addr = {m_page, b8};
                        end else begin
                            e_wen = 1'b1; e_addr = 16'h2004;
                            e_data = mem[{m_page, b8}]; chk_d = 1'b1;
                        end
                    end
                end
                bad = (cpu_rdy !== e_rdy) || (dma_active !== e_act) ||
                      (bus_ren !== e_ren) || (bus_wen !== e_wen) ||
                      (chk_a && bus_addr !== e_addr) || (chk_d && bus_data_out !== e_data);
                tests++;
                if (bad) begin
                    fails++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL cycle_model cyc=%0d got rdy=%0b act=%0b addr=%h data=%h ren=%0b wen=%0b expected rdy=%0b act=%0b addr=%h data=%h ren=%0b wen=%0b",
                                 cyc, cpu_rdy, dma_active, bus_addr, bus_data_out, bus_ren, bus_wen,
                                 e_rdy, e_act, e_addr, e_data, e_ren, e_wen);
                    end
                end
                if (ALIGN_ON && dma_active === 1'b1 && bus_ren === 1'b1) begin
                    tests++;
                    if (cyc % 2 != 0) begin
                        fails++;
                        if (shown < 20) begin
                            shown++;
                            $display("FAIL read_on_get cyc=%0d got parity=1 expected parity=0", cyc);
                        end
                    end
                end
                if (dma_active === 1'b1 && bus_wen === 1'b1) wq.push_back(bus_data_out);
                if (dma_active === 1'b1 && bus_ren === 1'b1) rq.push_back(bus_addr);
                case (mode)
                    0: if (cpu_wen && cpu_addr == 16'h4014) begin
                           m_page = cpu_data_out; mode = 1;
                       end
                    1: if (!cpu_wen) begin
                           mode = 2;
                           rs = (ALIGN_ON && ((cyc + 1) % 2 == 1)) ? cyc + 2 : cyc + 1;
                       end
                    default: if (cyc >= rs && cyc - rs == 511) mode = 0;
                endcase
                cyc++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one CPU cycle, then advance to 1ns after the next rising edge.
    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
        cpu_addr = a; cpu_data_out = d; cpu_ren = r; cpu_wen = w;
        @(posedge clk); #1;
    endtask

    // Trigger a DMA from 'page'. want >= 0 places the halt cycle on that
    // parity; 'extra' CPU writes follow the trigger; 'noise' sprinkles $4014
    // writes into the transfer. len = stalled cycles from the halt cycle on.
    task automatic do_dma(input logic [7:0] page, input int want, input int extra,
                          input bit noise, output int len);
        int pre = 0;
        int n = 0;
        if (want >= 0) pre = (want + cyc + 1 + extra) % 2;
        repeat (pre) drive(16'h8000, 8'h00, 1'b1, 1'b0);
        wq.delete(); rq.delete();
        drive(16'h4014, page, 1'b0, 1'b1);
        chk("rdy_low_after_trigger", 32'(cpu_rdy), 32'd0);
        for (int i = 0; i < extra; i++) begin
            cpu_addr = 16'(16'h01FD - i); cpu_data_out = 8'(8'hC0 + i);
            cpu_ren = 1'b0; cpu_wen = 1'b1;
            #1;
            chk("ext_write_pass", 32'(bus_wen === 1'b1 && bus_addr === cpu_addr &&
                                      dma_active === 1'b0 && cpu_rdy === 1'b0), 32'd1);
            @(posedge clk); #1;
        end
        while (cpu_rdy === 1'b0 && n < 700) begin
            if (noise && n % 37 == 5) drive(16'h4014, 8'h77, 1'b0, 1'b1);
            else                      drive(16'h8123, 8'h00, 1'b1, 1'b0);
            n++;
        end
        if (n >= 700) chk("dma_timeout", 32'(n), 32'd514);
        len = n;
    endtask

    initial begin
        int len, zeros, n;
        logic w;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_addr = 16'h8000; cpu_ren = 1'b1; cpu_wen = 1'b0;
        #1;
        chk("reset_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_active", 32'(dma_active), 32'd0);
        chk("reset_pass_addr", 32'(bus_addr), 32'h8000);
        @(posedge clk); #1;

        // Passthrough
        drive(16'h8000, 8'h00, 1'b1, 1'b0);
        cpu_addr = 16'h0300; cpu_data_out = 8'h55; cpu_ren = 1'b0; cpu_wen = 1'b1;
        #1;
        chk("pass_write", 32'({bus_addr, bus_data_out, bus_ren, bus_wen, cpu_rdy, dma_active}),
            32'({16'h0300, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0}));
        @(posedge clk); #1;
        drive(16'h8000, 8'h00, 1'b1, 1'b0);

        // Basic DMA, halt cycle on PUT
        do_dma(8'h02, 1, 0, 1'b0, len);
        chk("basic_len", 32'(len), 32'd513);
        chk("basic_count", 32'(wq.size()), 32'd256);
        if (wq.size() == 256) begin
            chk("basic_first", 32'(wq[0]), 32'hA5);
            chk("basic_second", 32'(wq[1]), 32'hA4);
            chk("basic_last", 32'(wq[255]), 32'h5A);
            chk("basic_last_rd", 32'(rq[255]), 32'h02FF);
        end

        // Halt cycle on GET
        drive(16'h8000, 8'h00, 1'b1, 1'b0);
        do_dma(8'h02, 0, 0, 1'b0, len);
        chk("align_len", 32'(len), ALIGN_ON ? 32'd514 : 32'd513);

        // Write-extended halt
        drive(16'h8000, 8'h00, 1'b1, 1'b0);
        do_dma(8'h03, 1, 2, 1'b0, len);
        chk("ext_len", 32'(len), 32'd513);
        chk("ext_first_rd", (rq.size() > 0) ? 32'(rq[0]) : 32'hDEAD, 32'h0300);

        // Page $FF with ignored $4014 writes during the transfer
        drive(16'h8000, 8'h00, 1'b1, 1'b0);
        do_dma(8'hFF, 0, 0, 1'b1, len);
        zeros = 0;
        foreach (rq[i]) if (rq[i] == 16'h0000) zeros++;
        chk("wrap_no_zero", 32'(zeros), 32'd0);
        chk("wrap_count", 32'(rq.size()), 32'd256);
        if (rq.size() == 256) begin
            chk("wrap_first", 32'(rq[0]), 32'hFF00);
            chk("wrap_last", 32'(rq[255]), 32'hFFFF);
        end

        // Retrigger in the very cycle the DMA returns to idle
        do_dma(8'h04, -1, 0, 1'b0, len);
        chk("b2b_count", 32'(wq.size()), 32'd256);
        if (wq.size() > 0) chk("b2b_first", 32'(wq[0]), 32'(mem[16'h0400]));

        // Reset after write 100
        drive(16'h8000, 8'h00, 1'b1, 1'b0);
        wq.delete(); rq.delete();
        drive(16'h4014, 8'h03, 1'b0, 1'b1);
        n = 0;
        while (wq.size() < 100 && n < 400) begin
            drive(16'h8123, 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk("rst_reach_100", 32'(wq.size()), 32'd100);
        rst = 1'b1;
        drive(16'h8123, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_active", 32'(dma_active), 32'd0);
        repeat (20) drive(16'h8000, 8'h00, 1'b1, 1'b0);
        chk("rst_no_more_writes", 32'(wq.size()), 32'd100);
        do_dma(8'h03, -1, 0, 1'b0, len);
        chk("restart_first_rd", (rq.size() > 0) ? 32'(rq[0]) : 32'hDEAD, 32'h0300);
        chk("restart_count", 32'(wq.size()), 32'd256);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 15000; i++) begin
            if ($urandom % 3000 == 0) begin
                rst = 1'b1;
                drive(16'($urandom), 8'($urandom), 1'b1, 1'b0);
                rst = 1'b0;
            end else if (cpu_rdy) begin
                if ($urandom % 40 == 0) drive(16'h4014, 8'($urandom), 1'b0, 1'b1);
                else begin
                    w = ($urandom % 3 == 0);
                    drive(16'($urandom), 8'($urandom), !w, w);
                end
            end else begin
                w = ($urandom % 8 == 0);
                a = ($urandom % 4 == 0) ? 16'h4014 : 16'($urandom);
                drive(a, 8'($urandom), !w, w);
            end
        end
        repeat (4) drive(16'h8000, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
